// File: rtl/vx_vec_scoreboard_pkg.sv
// Shared types for the issue-slot scoreboard: instruction layout and sizing.
// Optional vector tracking is enabled by defining SCOREBOARD_VEC_EN.
`ifndef NR_BITS
`define NR_BITS 6
`endif

package vx_vec_scoreboard_pkg;
    localparam int ISSUE_WIS   = 4;
    localparam int ISSUE_WIS_W = 2;
    localparam int NR_W        = `NR_BITS;
    localparam int NUM_REGS    = 2 ** `NR_BITS;
    localparam int NUM_VREGS   = 32;
    localparam int NV_W        = 5;

    typedef struct packed {
        logic [31:0]            pc;
        logic [ISSUE_WIS_W-1:0] wis;
        logic                   wb;
        logic [NR_W-1:0]        rd;
        logic [NR_W-1:0]        rs1;
        logic [NR_W-1:0]        rs2;
        logic [NR_W-1:0]        rs3;
        logic                   is_vec;
        logic [NV_W-1:0]        vd;
        logic [NV_W-1:0]        vs1;
        logic [NV_W-1:0]        vs2;
    } data_t;
endpackage

// File: rtl/vx_vec_scoreboard_pending_table.sv
// Per-warp pending-write bit table with set-wins-over-clear update and
// combinational read ports that see only the registered state.
module vx_sb_pending_table #(
    parameter int NUM_WIS   = 4,
    parameter int N         = 64,
    parameter int WIS_W     = 2,
    parameter int IDX_W     = 6,
    parameter int NUM_RD    = 4,
    parameter bit MASK_ZERO = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           set_en,
    input  logic [WIS_W-1:0]               set_wis,
    input  logic [IDX_W-1:0]               set_idx,
    input  logic                           clr_en,
    input  logic [WIS_W-1:0]               clr_wis,
    input  logic [IDX_W-1:0]               clr_idx,
    input  logic [WIS_W-1:0]               rd_wis,
    input  logic [NUM_RD-1:0][IDX_W-1:0]   rd_idx,
    output logic [NUM_RD-1:0]              rd_pend
);
    logic [NUM_WIS-1:0][N-1:0] pend_q, pend_d;

    // Clear applied first so a same-cycle set on the same bit wins.
    always_comb begin
        pend_d = pend_q;
        if (clr_en)
            pend_d[clr_wis][clr_idx] = 1'b0;
        if (set_en && (!MASK_ZERO || set_idx != '0))
            pend_d[set_wis][set_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        assign rd_pend[g] = pend_q[rd_wis][rd_idx[g]] && (!MASK_ZERO || rd_idx[g] != '0);
    end
endmodule

// File: rtl/vx_vec_scoreboard.sv
// RAW/WAW hazard gate between ibuffer and operand collector; holds an
// instruction until its registers are clear. Vector tracking: SCOREBOARD_VEC_EN.
module vx_vec_scoreboard
    import vx_vec_scoreboard_pkg::*;
#(
    parameter int NUM_WIS   = vx_vec_scoreboard_pkg::ISSUE_WIS,
    parameter int NUM_REGS  = vx_vec_scoreboard_pkg::NUM_REGS,
    parameter int NUM_VREGS = vx_vec_scoreboard_pkg::NUM_VREGS,
    parameter int PERF_W    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  data_t                  in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output data_t                  out_data,
    input  logic                   out_ready,
    input  logic                   wb_valid,
    input  logic [ISSUE_WIS_W-1:0] wb_wis,
    input  logic [NR_W-1:0]        wb_rd,
    input  logic                   wb_is_vec,
    input  logic                   wb_eop,
    output logic [PERF_W-1:0]      perf_stalls
);
    logic [3:0]        r_pend;
    logic              hazard_r, hazard_v, hazard, accept;
    logic              vec_set, vec_clr;
    logic              out_valid_q, out_valid_d;
    data_t             out_data_q, out_data_d;
    logic [PERF_W-1:0] perf_q, perf_d;

    vx_sb_pending_table #(
        .NUM_WIS(NUM_WIS), .N(NUM_REGS), .WIS_W(ISSUE_WIS_W),
        .IDX_W(NR_W), .NUM_RD(4), .MASK_ZERO(1'b1)
    ) u_scalar (
        .clk     (clk),
        .reset   (reset),
        .set_en  (accept && in_data.wb && !vec_set),
        .set_wis (in_data.wis),
        .set_idx (in_data.rd),
        .clr_en  (wb_valid && wb_eop && !vec_clr),
        .clr_wis (wb_wis),
        .clr_idx (wb_rd),
        .rd_wis  (in_data.wis),
        .rd_idx  ({in_data.rd, in_data.rs3, in_data.rs2, in_data.rs1}),
        .rd_pend (r_pend)
    );

    assign hazard_r = |(r_pend & {in_data.wb, 3'b111});

`ifdef SCOREBOARD_VEC_EN
    logic [2:0] v_pend;

    assign vec_set = in_data.is_vec;
    assign vec_clr = wb_is_vec;

    vx_sb_pending_table #(
        .NUM_WIS(NUM_WIS), .N(NUM_VREGS), .WIS_W(ISSUE_WIS_W),
        .IDX_W(NV_W), .NUM_RD(3), .MASK_ZERO(1'b1)
    ) u_vector (
        .clk     (clk),
        .reset   (reset),
        .set_en  (accept && in_data.wb && in_data.is_vec),
        .set_wis (in_data.wis),
        .set_idx (in_data.vd),
        .clr_en  (wb_valid && wb_eop && wb_is_vec),
        .clr_wis (wb_wis),
        .clr_idx (wb_rd[NV_W-1:0]),
        .rd_wis  (in_data.wis),
        .rd_idx  ({in_data.vd, in_data.vs2, in_data.vs1}),
        .rd_pend (v_pend)
    );

    assign hazard_v = in_data.is_vec && |(v_pend & {in_data.wb, 2'b11});
`else
    logic unused_vec;

    assign vec_set    = 1'b0;
    assign vec_clr    = 1'b0;
    assign hazard_v   = 1'b0;
    assign unused_vec = ^{in_data.is_vec, in_data.vd, in_data.vs1, in_data.vs2,
                          wb_is_vec, NUM_VREGS[0]};
`endif

    assign hazard   = hazard_r || hazard_v;
    assign in_ready = !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
        end
        perf_d = perf_q + PERF_W'(in_valid && hazard);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            perf_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            perf_q      <= perf_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign perf_stalls = perf_q;
endmodule
